paralelo_serial_phy_tx: RTL

- Transmit-side parallel-to-serial stage of the PHY; sits directly upstream of serial_paralelo_phy_tx and drives that block's data_in.
- Sends SYNC_COUNT COM symbols (0xBC) after reset, then serializes accepted bytes MSB-first, one bit per clk_32f.
- Sends the IDLE symbol (0x7C) on any byte slot with no valid data.
- Single clock domain (clk_32f); byte rate is clk_32f/8.

---
 rtl/paralelo_serial_phy_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/paralelo_serial_phy_tx.sv
// ---------------------------------------------------------------------------
// paralelo_serial_phy_tx
//
// Transmit-side parallel-to-serial stage of the PHY. After reset it sends
// SYNC_COUNT COM symbols. It then serializes accepted bytes MSB-first, one
// bit per clk_32f. A byte slot with no valid data carries the IDLE symbol.
// Symbols are continuous 8-cycle frames with no gaps between them.
//
// Ports:
//   clk_32f         bit clock; all state updates on its rising edge
//   default_values  asynchronous active-low reset
//   data_in[7:0]    parallel byte from the upstream source
//   valid_in        data_in holds a byte to send
//   ready_out       high on the last bit cycle of a symbol while in RUN;
//                   a byte transfers on a rising edge with valid_in && ready_out
//   data_out        serial bit stream, MSB first (shift_reg[7])
//   active          high while in RUN
//   idle_out        high while the IDLE symbol is on data_out
// ---------------------------------------------------------------------------
module paralelo_serial_phy_tx #(
    parameter logic [7:0]  COM_SYMBOL  = 8'hBC,
    parameter logic [7:0]  IDLE_SYMBOL = 8'h7C,
    parameter int unsigned SYNC_COUNT  = 4
) (
    input  logic       clk_32f,
    input  logic       default_values,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active,
    output logic       idle_out
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // This is the value com_cnt holds when the final COM symbol is loaded.
    // Comparing against it is the same as testing com_cnt+1 == SYNC_COUNT,
    // and it avoids a carry into a fifth bit.
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [2:0] bit_cnt;
    logic [2:0] bit_next;
    logic [3:0] com_cnt;
    logic [3:0] com_next;
    logic       idle_flag;
    logic       idle_next;
    logic       load_slot;

    // bit_cnt resets to 7, so the first edge after reset is already a load
    // slot. That edge puts the first COM symbol straight onto the line.
    assign load_slot = (bit_cnt == 3'd7);

    always_ff @(posedge clk_32f or negedge default_values) begin
        if (!default_values) begin
            state     <= SYNC;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd7;
            com_cnt   <= 4'd0;
            idle_flag <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
            com_cnt   <= com_next;
            idle_flag <= idle_next;
        end
    end

    // Between symbol boundaries the register shifts left, so shift_reg[7]
    // walks from MSB to LSB. At a boundary the next symbol is loaded in
    // place of the shift. This gives back-to-back symbols with no bubble.
    always_comb begin
        state_next = state;
        shift_next = {shift_reg[6:0], 1'b0};
        bit_next   = bit_cnt + 3'd1;
        com_next   = com_cnt;
        idle_next  = idle_flag;

        if (load_slot) begin
            bit_next = 3'd0;
            unique case (state)
                SYNC: begin
                    shift_next = COM_SYMBOL;
                    idle_next  = 1'b0;
                    // com_cnt stops at its maximum and is not used in RUN.
                    if (com_cnt != 4'hF) begin
                        com_next = com_cnt + 4'd1;
                    end
                    if (com_cnt == SYNC_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        shift_next = data_in;
                        idle_next  = 1'b0;
                    end else begin
                        shift_next = IDLE_SYMBOL;
                        idle_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = SYNC;
                end
            endcase
        end
    end

    // ready_out is decoded from registers only, so it does not depend on
    // valid_in. The source can therefore look at it without forming a loop.
    assign ready_out = (state == RUN) && load_slot;
    assign active    = (state == RUN);
    assign data_out  = shift_reg[7];
    assign idle_out  = idle_flag;

endmodule
